dual_rail_decoder_seq: RTL

- Clocked, parametrised successor to the pulse-based dual-rail decoder.
- Each of SIZE address bits arrives as a one-cycle pulse on either its true rail (in_data[i]) or its complement rail (in_not[i]); arrivals may be staggered across cycles.
- Collects one complete token, then emits a one-hot out_data pulse with an out_clk strobe.
- Adds behaviour the earlier decoder lacks: arrival-window timeout, rail-conflict and overrun detection, and a saturating decode counter.
- Sits between dual-rail address sources and one-hot select consumers in the pulse-logic test fabric.

---
 rtl/dual_rail_decoder_seq_if.sv | 26 ++
 rtl/dual_rail_decoder_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dual_rail_decoder_seq_if.sv
// Dual-rail address inputs and one-hot decode/status outputs of dual_rail_decoder_seq.
// The master side drives the rail pulses; the slave side is the decoder.
interface dual_rail_decoder_seq_if #(
    parameter int unsigned SIZE    = 2,
    parameter int unsigned COUNT_W = 8
);
    logic [SIZE-1:0]        in_data;
    logic [SIZE-1:0]        in_not;
    logic [(1<<SIZE)-1:0]   out_data;
    logic                   out_clk;
    logic                   busy;
    logic                   err_conflict;
    logic                   err_timeout;
    logic                   err_overrun;
    logic [COUNT_W-1:0]     decode_count;

    modport master (
        output in_data, in_not,
        input  out_data, out_clk, busy, err_conflict, err_timeout, err_overrun, decode_count
    );

    modport slave (
        input  in_data, in_not,
        output out_data, out_clk, busy, err_conflict, err_timeout, err_overrun, decode_count
    );
endinterface

// File: rtl/dual_rail_decoder_seq.sv
// Collects staggered dual-rail bit pulses into one token and emits a registered one-hot pulse,
// with arrival-window timeout, rail-conflict/overrun flags and a saturating decode counter.
module dual_rail_decoder_seq #(
    parameter int unsigned SIZE        = 2,
    parameter int unsigned PULSE_WIDTH = 2,
    parameter int unsigned TIMEOUT     = 4,
    parameter int unsigned COUNT_W     = 8
) (
    input logic                   clk,
    input logic                   rst,
    dual_rail_decoder_seq_if.slave bus
);
    localparam int unsigned OUT_W   = 1 << SIZE;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam int unsigned EMIT_W  = $clog2(PULSE_WIDTH + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);
    localparam logic [EMIT_W-1:0]  EMIT_MAX  = EMIT_W'(PULSE_WIDTH);
    localparam logic [OUT_W-1:0]   ONE_HOT0  = OUT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

    state_e             state_q, state_d;
    logic [SIZE-1:0]    arrived_q, arrived_d;
    logic [SIZE-1:0]    value_q, value_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [EMIT_W-1:0]  emit_cnt_q, emit_cnt_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_clk_q, out_clk_d;
    logic               busy_q, busy_d;
    logic               err_conflict_q, err_conflict_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_overrun_q, err_overrun_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [SIZE-1:0]    pulses;
    logic [SIZE-1:0]    arr_new;
    logic [SIZE-1:0]    val_new;
    logic [TIMER_W-1:0] timer_next;
    logic               any_pulse;
    logic               conflict;
    logic               complete;
    logic               timed_out;

    always_comb begin
        pulses     = bus.in_data | bus.in_not;
        any_pulse  = |pulses;
        // arrived_q is always zero in IDLE, so one check covers both collecting states
        conflict   = (|(bus.in_data & bus.in_not)) | (|(pulses & arrived_q));
        arr_new    = arrived_q | pulses;
        val_new    = (value_q & ~pulses) | bus.in_data;
        complete   = &arr_new;
        timer_next = (state_q == StIdle) ? TIMER_W'(1) : timer_q + TIMER_W'(1);
        timed_out  = (timer_next == TIMER_MAX);
    end

    always_comb begin
        state_d        = state_q;
        arrived_d      = arrived_q;
        value_d        = value_q;
        timer_d        = timer_q;
        emit_cnt_d     = emit_cnt_q;
        out_data_d     = out_data_q;
        count_d        = count_q;
        err_conflict_d = 1'b0;
        err_timeout_d  = 1'b0;
        err_overrun_d  = 1'b0;

        unique case (state_q)
            StIdle, StCollect: begin
                if (state_q == StCollect || any_pulse) begin
                    if (conflict) begin
                        err_conflict_d = 1'b1;
                        state_d        = StIdle;
                        arrived_d      = '0;
                        value_d        = '0;
                        timer_d        = '0;
                    end else if (complete) begin
                        state_d    = StEmit;
                        arrived_d  = arr_new;
                        value_d    = val_new;
                        timer_d    = '0;
                        emit_cnt_d = EMIT_W'(1);
                        out_data_d = ONE_HOT0 << val_new;
                        if (count_q != COUNT_MAX) count_d = count_q + COUNT_W'(1);
                    end else if (timed_out) begin
                        err_timeout_d = 1'b1;
                        state_d       = StIdle;
                        arrived_d     = '0;
                        value_d       = '0;
                        timer_d       = '0;
                    end else begin
                        state_d   = StCollect;
                        arrived_d = arr_new;
                        value_d   = val_new;
                        timer_d   = timer_next;
                    end
                end
            end
            StEmit: begin
                err_overrun_d = any_pulse;
                if (emit_cnt_q == EMIT_MAX) begin
                    state_d    = StIdle;
                    arrived_d  = '0;
                    value_d    = '0;
                    emit_cnt_d = '0;
                    out_data_d = '0;
                end else begin
                    emit_cnt_d = emit_cnt_q + EMIT_W'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                arrived_d  = '0;
                value_d    = '0;
                timer_d    = '0;
                emit_cnt_d = '0;
                out_data_d = '0;
            end
        endcase

        out_clk_d = |out_data_d;
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            arrived_q      <= '0;
            value_q        <= '0;
            timer_q        <= '0;
            emit_cnt_q     <= '0;
            out_data_q     <= '0;
            out_clk_q      <= 1'b0;
            busy_q         <= 1'b0;
            err_conflict_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            arrived_q      <= arrived_d;
            value_q        <= value_d;
            timer_q        <= timer_d;
            emit_cnt_q     <= emit_cnt_d;
            out_data_q     <= out_data_d;
            out_clk_q      <= out_clk_d;
            busy_q         <= busy_d;
            err_conflict_q <= err_conflict_d;
            err_timeout_q  <= err_timeout_d;
            err_overrun_q  <= err_overrun_d;
            count_q        <= count_d;
        end
    end

    assign bus.out_data     = out_data_q;
    assign bus.out_clk      = out_clk_q;
    assign bus.busy         = busy_q;
    assign bus.err_conflict = err_conflict_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_overrun  = err_overrun_q;
    assign bus.decode_count = count_q;
endmodule
